// File: rtl/zigzag_pingpong_buf.sv
// Ping-pong coefficient buffer: one bank takes a block in raster or column order while
// the other bank streams out its block in JPEG zigzag order over a ready/valid port.
module zigzag_pingpong_buf #(
    parameter int DATA_W    = 12,
    parameter int BLK_N     = 8,
    parameter int COL_MAJOR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [2*$clog2(BLK_N)-1:0]   out_idx,
    output logic                         out_last
);
    localparam int LG    = $clog2(BLK_N);
    localparam int AW    = 2 * LG;
    localparam int DEPTH = 2 * BLK_N * BLK_N;
    localparam logic [LG-1:0] EDGE = LG'(BLK_N - 1);
    localparam logic [AW-1:0] LAST = AW'(BLK_N * BLK_N - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        full, full_next;
    logic              wbank, rbank;
    logic [AW-1:0]     wcnt, idx, waddr;
    logic [LG-1:0]     r, c, r_next, c_next;
    logic              in_xfer, load, release_blk;

    // Only a full write bank blocks input, which means both banks hold a block.
    assign in_ready    = !full[wbank];
    assign in_xfer     = in_valid && in_ready && !flush;
    assign waddr       = (COL_MAJOR != 0) ? {wcnt[LG-1:0], wcnt[AW-1:LG]} : wcnt;
    assign load        = (!out_valid || out_ready) && full[rbank];
    // The bank is freed as soon as its last coefficient moves into the output
    // register, so a block filling in the same cycle keeps the writer running.
    assign release_blk = load && (idx == LAST);

    always_comb begin
        r_next = r;
        c_next = c;
        if (!(r[0] ^ c[0])) begin
            if (c == EDGE) begin
                r_next = r + 1'b1;
            end else if (r == '0) begin
                c_next = c + 1'b1;
            end else begin
                r_next = r - 1'b1;
                c_next = c + 1'b1;
            end
        end else begin
            if (r == EDGE) begin
                c_next = c + 1'b1;
            end else if (c == '0) begin
                r_next = r + 1'b1;
            end else begin
                r_next = r + 1'b1;
                c_next = c - 1'b1;
            end
        end
    end

    always_comb begin
        full_next = full;
        if (in_xfer && (wcnt == LAST)) full_next[wbank] = 1'b1;
        if (release_blk)               full_next[rbank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (in_xfer) mem[{wbank, waddr}] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wcnt      <= '0;
            idx       <= '0;
            r         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else if (flush) begin
            full      <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wcnt      <= '0;
            idx       <= '0;
            r         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            full <= full_next;
            if (in_xfer) begin
                if (wcnt == LAST) begin
                    wcnt  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mem[{rbank, r, c}];
                out_idx   <= idx;
                out_last  <= (idx == LAST);
                if (idx == LAST) begin
                    idx   <= '0;
                    r     <= '0;
                    c     <= '0;
                    rbank <= ~rbank;
                end else begin
                    idx <= idx + 1'b1;
                    r   <= r_next;
                    c   <= c_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_zigzag_pingpong_buf.sv
// Bench for zigzag_pingpong_buf: 8x8 raster and column-major instances share stimulus,
// a 4x4 instance covers the small block and flush; outputs go through expected queues.
module tb_zigzag_pingpong_buf;
    typedef int iq_t[$];
    typedef struct {int idx; int data;} spot_t;

    logic        clk, rst, flush;
    logic        in_valid, out_ready;
    logic [11:0] a_data, b_data;
    logic        a_in_ready, b_in_ready, a_out_valid, b_out_valid, a_out_last, b_out_last;
    logic [11:0] a_out_data, b_out_data;
    logic [5:0]  a_out_idx, b_out_idx;
    logic        c_in_valid, c_out_ready, c_in_ready, c_out_valid, c_out_last;
    logic [11:0] c_data, c_out_data;
    logic [3:0]  c_out_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [11:0] exp_a[$];
    logic [11:0] exp_b[$];
    logic [11:0] exp_c[$];
    int a_idx_e = 0, b_idx_e = 0, c_idx_e = 0;
    int a_got[64];
    int a_xfers[$];
    iq_t zz8;
    spot_t t1_tab[13];
    int zz4_tab[16];

    zigzag_pingpong_buf #(.DATA_W(12), .BLK_N(8), .COL_MAJOR(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(a_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last));

    zigzag_pingpong_buf #(.DATA_W(12), .BLK_N(8), .COL_MAJOR(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(b_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last));

    zigzag_pingpong_buf #(.DATA_W(12), .BLK_N(4), .COL_MAJOR(0)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_idx(c_out_idx), .out_last(c_out_last));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Zigzag order by walking anti-diagonals: odd diagonals go down-left, even go up-right.
    function automatic iq_t zz_order(input int n);
        iq_t q;
        for (int s = 0; s < 2 * n - 1; s++) begin
            int lo = (s > n - 1) ? s - n + 1 : 0;
            int hi = (s < n - 1) ? s : n - 1;
            if (s % 2 == 1) for (int rr = lo; rr <= hi; rr++) q.push_back(rr * n + s - rr);
            else            for (int rr = hi; rr >= lo; rr--) q.push_back(rr * n + s - rr);
        end
        return q;
    endfunction

    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            if (exp_a.size() == 0) check("a_unexpected_output", a_out_data, -1);
            else begin
                check("a_data", a_out_data, exp_a.pop_front());
                check("a_idx", a_out_idx, a_idx_e);
                check("a_last", a_out_last, a_idx_e == 63);
            end
            a_got[a_out_idx] = a_out_data;
            a_idx_e = (a_idx_e + 1) % 64;
            a_xfers.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && out_ready) begin
            if (exp_b.size() == 0) check("b_unexpected_output", b_out_data, -1);
            else begin
                check("b_data", b_out_data, exp_b.pop_front());
                check("b_idx", b_out_idx, b_idx_e);
                check("b_last", b_out_last, b_idx_e == 63);
            end
            b_idx_e = (b_idx_e + 1) % 64;
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid && c_out_ready) begin
            if (exp_c.size() == 0) check("c_unexpected_output", c_out_data, -1);
            else begin
                check("c_data", c_out_data, exp_c.pop_front());
                check("c_idx", c_out_idx, c_idx_e);
                check("c_last", c_out_last, c_idx_e == 15);
            end
            c_idx_e = (c_idx_e + 1) % 16;
        end
    end

    // Block values are base+address; the column-major instance receives them transposed.
    task automatic send_block8(input int base, input int count, output int stalls);
        stalls = 0;
        for (int w = 0; w < count; w++) begin
            int guard = 0;
            in_valid = 1'b1;
            a_data = 12'(base + w);
            b_data = 12'(base + (w % 8) * 8 + w / 8);
            @(negedge clk);
            while (!a_in_ready) begin
                stalls++;
                guard++;
                if (guard > 2000) begin
                    check("send8_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (count == 64)
            foreach (zz8[i]) begin
                exp_a.push_back(12'(base + zz8[i]));
                exp_b.push_back(12'(base + zz8[i]));
            end
    endtask

    task automatic send_c(input int base, input int count);
        for (int w = 0; w < count; w++) begin
            int guard = 0;
            c_in_valid = 1'b1;
            c_data = 12'(base + w);
            @(negedge clk);
            while (!c_in_ready) begin
                guard++;
                if (guard > 2000) begin
                    check("sendc_timeout", 0, 1);
                    c_in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        c_in_valid = 1'b0;
        if (count == 16) foreach (zz4_tab[i]) exp_c.push_back(12'(base + zz4_tab[i]));
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_a.size() != 0 || exp_b.size() != 0 || exp_c.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                check("drain_timeout", exp_a.size() + exp_b.size() + exp_c.size(), 0);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_spots();
        foreach (t1_tab[i]) check($sformatf("spot_idx%0d", t1_tab[i].idx), a_got[t1_tab[i].idx], t1_tab[i].data);
    endtask

    initial begin
        int s1, s2, s3;
        zz8 = zz_order(8);
        t1_tab = '{'{0, 0}, '{1, 1}, '{2, 8}, '{3, 16}, '{4, 9}, '{5, 2}, '{6, 3},
                   '{7, 10}, '{8, 17}, '{9, 24}, '{61, 55}, '{62, 62}, '{63, 63}};
        zz4_tab = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_data = '0; b_data = '0; c_in_valid = 1'b0; c_data = '0; c_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_out_idx", a_out_idx, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_in_ready", a_in_ready, 1);

        // T1 + T4: raster ramp and transposed ramp give the same zigzag stream
        @(posedge clk); #1;
        send_block8(0, 64, s1);
        @(negedge clk);
        check("lat_not_yet_valid", a_out_valid, 0);
        @(negedge clk);
        check("lat_first_valid", a_out_valid, 1);
        drain();
        check_spots();

        // T2: three back-to-back blocks, no input stall, no output bubble
        a_xfers.delete();
        @(posedge clk); #1;
        send_block8(1000, 64, s1);
        send_block8(1100, 64, s2);
        send_block8(1200, 64, s3);
        check("t2_input_stalls", s1 + s2 + s3, 0);
        drain();
        check("t2_xfer_count", a_xfers.size(), 192);
        if (a_xfers.size() == 192) check("t2_gap_free_span", a_xfers[191] - a_xfers[0], 191);

        // T3: downstream stalled; two blocks fill both banks, then in_ready falls
        a_xfers.delete();
        @(posedge clk); #1 out_ready = 1'b0;
        send_block8(2000, 64, s1);
        send_block8(2100, 64, s2);
        check("t3_accept_stalls", s1 + s2, 0);
        in_valid = 1'b1;
        a_data = 12'd2200;
        b_data = 12'd2200;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_in_ready_low", a_in_ready, 0);
            check("t3_hold_valid", a_out_valid, 1);
            check("t3_hold_data", a_out_data, 2000);
            check("t3_hold_idx", a_out_idx, 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        send_block8(2200, 64, s3);
        drain();
        check("t3_xfer_count", a_xfers.size(), 192);

        // T5: async reset while a block is stalled in the output and another half-written
        @(posedge clk); #1 out_ready = 1'b0;
        send_block8(300, 64, s1);
        repeat (3) @(negedge clk);
        check("t5_stalled_valid", a_out_valid, 1);
        @(posedge clk); #1;
        send_block8(400, 30, s1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid_a", a_out_valid, 0);
        check("t5_async_valid_b", b_out_valid, 0);
        check("t5_async_in_ready", a_in_ready, 1);
        exp_a.delete(); exp_b.delete();
        a_idx_e = 0; b_idx_e = 0;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        send_block8(0, 64, s1);
        drain();
        check_spots();

        // T6: 4x4 block, then a partial block cleared by flush (flush beats a transfer)
        @(posedge clk); #1;
        send_c(0, 16);
        drain();
        @(posedge clk); #1;
        send_c(50, 7);
        c_in_valid = 1'b1; c_data = 12'd999; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; c_in_valid = 1'b0;
        @(negedge clk);
        check("t6_flush_valid", c_out_valid, 0);
        check("t6_flush_in_ready", c_in_ready, 1);
        check("t6_flush_idx", c_out_idx, 0);
        @(posedge clk); #1;
        send_c(100, 16);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
